booth_dot_accumulator: RTL and testbench
========================================

Name: booth_dot_accumulator

Overview:
- Downstream consumer of the 8x8 signed radix-8 Booth multiplier.
- Accepts a stream of 16-bit signed products over a valid/ready handshake and accumulates a programmed number of them into a wider signed accumulator, with saturation.
- Presents the dot-product result on a second valid/ready handshake.
- Sits between the combinational multiplier (registered upstream) and the result sink.

Parameters:
PROD_W, 16, product width; matches multiplier output
ACC_W, 24, accumulator/result width; must be >= PROD_W
LEN_W, 8, width of the term-count field

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset; asynchronous assert, active-low
start  in  1  pulse; begins a new accumulation; honoured only in IDLE
len  in  LEN_W  number of products to accumulate; sampled when start is honoured
busy  out  1  high in any state other than IDLE
prod_valid  in  1  upstream product valid
prod_ready  out  1  block can accept a product this cycle
prod_data  in  PROD_W  signed product
res_valid  out  1  result valid
res_ready  in  1  sink accepts result
res_data  out  ACC_W  signed accumulated result
res_sat  out  1  at least one saturation event occurred during this accumulation

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - acc, count, res_data, and sticky sat are all cleared.
  - busy, prod_ready, res_valid and res_sat are 0.
  - Reset mid-operation abandons the run with no result emitted.
- States: IDLE, ACCUM, HOLD.
- IDLE:
  - prod_ready=0.
  - On start=1 with len!=0: acc<=0, count<=len, sat<=0, go to ACCUM.
  - On start=1 with len==0: acc<=0, sat<=0, go to HOLD, so the result is 0 one cycle later.
- ACCUM:
  - prod_ready=1 combinationally from state only; it does not depend on prod_valid.
  - A handshake is prod_valid & prod_ready.
  - On a handshake: acc <= sat(acc + sext(prod_data)); count <= count-1.
  - If count==1 at the handshake, go to HOLD.
  - Without a handshake: acc and count hold.
  - start is ignored.
- Arithmetic:
  - Sign-extend prod_data to ACC_W+1 bits and compute the sum in ACC_W+1 bits.
  - If the two top bits differ, clamp to +(2^(ACC_W-1)-1) or -2^(ACC_W-1) according to the sign of the true sum, and set sticky sat.
  - Once saturated, later products continue to add to the clamped value; there is no "stuck" mode.
- HOLD:
  - res_valid=1; res_data=acc; res_sat=sat. All three are stable while res_ready=0.
  - prod_ready=0.
  - On res_ready=1: go to IDLE; res_valid drops the next cycle.
  - start is ignored, even when it coincides with res_ready. A new start is honoured only from IDLE, so there is at least one idle cycle between results.
- Latency: res_valid rises on the clock edge after the final product handshake. Back-to-back products at one per cycle are sustained.
- res_data and res_sat retain the last result after leaving HOLD and are only meaningful while res_valid=1.
- len is sampled once; changes during ACCUM/HOLD have no effect.

Decomposition:
- Shared package: the state enumeration (IDLE/ACCUM/HOLD) and the default width constants PROD_W=16, ACC_W=24, LEN_W=8. The multiplier's product width is tied to PROD_W.
- One sub-module is natural: booth_sat_add, a combinational ACC_W-bit signed add of a sign-extended PROD_W operand with clamp and overflow flag. The FSM, counter and handshake registers stay in the top module.

Test Plan:
1. Reset then start, len=3; products 100, -50, 7 at one per cycle; res_ready=1 -> res_valid asserts on the cycle after the third handshake with res_data=57, res_sat=0; the block returns to IDLE on the next cycle.
2. len=4; products 16384, -16256, 16384, -128 with prod_valid toggling 1/0 every cycle -> only handshaked beats count; res_data=16384; busy stays high throughout.
3. Backpressure: len=2; products 3, 4; hold res_ready=0 for 5 cycles -> res_valid=1 with res_data=7 stable all 5 cycles; prod_ready=0; a start pulse during HOLD is ignored; res_ready=1 -> IDLE.
4. Override ACC_W=18, len=9, all products 16384 -> res_data=131071 and res_sat=1. Then len=9 with all products -16256 -> res_data=-131072 and res_sat=1.
5. len=0 start -> res_valid one cycle later with res_data=0, res_sat=0; no product is accepted (prod_ready stays 0).
6. Assert rst_n=0 asynchronously mid-ACCUM after 2 of 5 products -> all outputs go to 0 immediately without a clock. A subsequent start with len=1 and product -1 gives res_data=-1, with no residue from the aborted run.

Source files
------------

// File: rtl/booth_dot_accumulator_pkg.sv
// Shared widths and FSM encoding for the Booth dot-product accumulator.
package booth_dot_accumulator_pkg;
  localparam int DEF_PROD_W = 16;
  localparam int DEF_ACC_W  = 24;
  localparam int DEF_LEN_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;
endpackage

// File: rtl/booth_sat_add.sv
// Combinational signed add of a sign-extended product into the accumulator.
// The result clamps to the ACC_W range, and ovf flags the clamp.
module booth_sat_add #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);
  logic [ACC_W:0] wide;

  // One guard bit is enough: the two top bits disagree exactly when the true sum left range.
  assign wide = {acc[ACC_W-1], acc} + {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod};
  assign ovf  = wide[ACC_W] ^ wide[ACC_W-1];

  always_comb begin
    sum = wide[ACC_W-1:0];
    if (ovf) begin
      sum = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
endmodule

// File: rtl/booth_dot_accumulator.sv
// Saturating dot-product accumulator for len signed products. The result is valid one cycle after the last product.
// One product can be accepted per cycle in ACCUM. The result is held while res_ready is low, and start is honoured only in IDLE.
module booth_dot_accumulator
  import booth_dot_accumulator_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_sat
);
  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [LEN_W-1:0] count;
  logic             sat;
  logic             ovf;
  logic             prod_hs;

  assign prod_ready = (state == ST_ACCUM);
  assign prod_hs    = prod_valid & prod_ready;
  // acc only changes on start or on a handshake, so it doubles as the held result.
  assign res_data   = acc;
  assign res_sat    = sat;

  booth_sat_add #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_sat_add (
    .acc  (acc),
    .prod (prod_data),
    .sum  (sum),
    .ovf  (ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      acc       <= '0;
      count     <= '0;
      sat       <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc  <= '0;
            sat  <= 1'b0;
            busy <= 1'b1;
            if (len != '0) begin
              count <= len;
              state <= ST_ACCUM;
            end else begin
              state     <= ST_HOLD;
              res_valid <= 1'b1;
            end
          end
        end
        ST_ACCUM: begin
          if (prod_hs) begin
            acc   <= sum;
            sat   <= sat | ovf;
            count <= count - 1'b1;
            if (count == LEN_W'(1)) begin
              state     <= ST_HOLD;
              res_valid <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (res_ready) begin
            state     <= ST_IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          res_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_booth_dot_accumulator.sv
// Bench for booth_dot_accumulator: a 24-bit and an 18-bit instance share stimulus.
// Uses table vectors, hand corner sequences and randomized jobs against a saturating-sum model.
module tb_booth_dot_accumulator;
  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [7:0]         len = '0;
  logic               prod_valid = 1'b0;
  logic signed [15:0] prod_data = '0;
  logic               res_ready = 1'b1;

  logic               busy_a, prod_ready_a, res_valid_a, res_sat_a;
  logic signed [23:0] res_a;
  logic               busy_b, prod_ready_b, res_valid_b, res_sat_b;
  logic signed [17:0] res_b;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_drop;
  logic signed [15:0] pq[$];

  always #5 clk = ~clk;

  booth_dot_accumulator dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy_a),
    .prod_valid(prod_valid), .prod_ready(prod_ready_a), .prod_data(prod_data),
    .res_valid(res_valid_a), .res_ready(res_ready), .res_data(res_a), .res_sat(res_sat_a)
  );

  booth_dot_accumulator #(.ACC_W(18)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy_b),
    .prod_valid(prod_valid), .prod_ready(prod_ready_b), .prod_data(prod_data),
    .res_valid(res_valid_b), .res_ready(res_ready), .res_data(res_b), .res_sat(res_sat_b)
  );

  typedef struct {
    int                 n;
    int                 mode;
    logic signed [15:0] p[12];
    longint             e24;
    bit                 s24;
    longint             e18;
    bit                 s18;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Saturating running sum of pq at the given accumulator width.
  task automatic model(input int w, output longint r, output bit s);
    longint mx, mn;
    mx = (longint'(1) << (w - 1)) - 1;
    mn = -(longint'(1) << (w - 1));
    r = 0;
    s = 1'b0;
    foreach (pq[i]) begin
      r += longint'(pq[i]);
      if (r > mx) begin r = mx; s = 1'b1; end
      else if (r < mn) begin r = mn; s = 1'b1; end
    end
  endtask

  // mode 0: valid every cycle, 1: valid on alternate cycles, 2: random gaps.
  task automatic feed(input string tag, input int mode);
    int idx = 0;
    int cyc = 0;
    int n = pq.size();
    @(negedge clk);
    start = 1'b1;
    len = n[7:0];
    @(negedge clk);
    start = 1'b0;
    busy_drop = 0;
    while (idx < n) begin
      if (cyc > 400) begin
        check({tag, "_feed_timeout"}, idx, n);
        break;
      end
      case (mode)
        0:       prod_valid = 1'b1;
        1:       prod_valid = (cyc % 2 == 0);
        default: prod_valid = ($urandom_range(0, 2) != 0);
      endcase
      prod_data = prod_valid ? pq[idx] : 16'($urandom);
      if (busy_a !== 1'b1) busy_drop++;
      if (prod_valid && prod_ready_a) idx++;
      cyc++;
      @(negedge clk);
    end
    prod_valid = 1'b0;
  endtask

  task automatic finish_job(input string tag, input longint e_a, input bit s_a,
                            input longint e_b, input bit s_b);
    check({tag, "_valid"}, res_valid_a, 1);
    check({tag, "_data24"}, res_a, e_a);
    check({tag, "_sat24"}, res_sat_a, s_a);
    check({tag, "_data18"}, res_b, e_b);
    check({tag, "_sat18"}, res_sat_b, s_b);
    res_ready = 1'b1;
    @(negedge clk);
    check({tag, "_idle"}, {res_valid_a, busy_a, res_valid_b}, 0);
  endtask

  initial begin
    longint ra, rb;
    bit sa, sb;

    vecs[0] = '{3, 0, '{100, -50, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 57, 0, 57, 0};
    vecs[1] = '{4, 1, '{16384, -16256, 16384, -128, 0, 0, 0, 0, 0, 0, 0, 0}, 16384, 0, 16384, 0};
    vecs[2] = '{9, 0, '{16384, 16384, 16384, 16384, 16384, 16384, 16384, 16384, 16384, 0, 0, 0},
                147456, 0, 131071, 1};
    vecs[3] = '{9, 0, '{-16256, -16256, -16256, -16256, -16256, -16256, -16256, -16256, -16256, 0, 0, 0},
                -146304, 0, -131072, 1};
    vecs[4] = '{10, 1, '{16384, 16384, 16384, 16384, 16384, 16384, 16384, 16384, 16384, -16384, 0, 0},
                131072, 0, 114687, 1};

    repeat (2) @(negedge clk);
    check("reset_outputs", {busy_a, prod_ready_a, res_valid_a, res_sat_a, res_a}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[v]) begin
      pq.delete();
      for (int i = 0; i < vecs[v].n; i++) pq.push_back(vecs[v].p[i]);
      feed($sformatf("vec%0d", v), vecs[v].mode);
      check($sformatf("vec%0d_busy_held", v), busy_drop, 0);
      finish_job($sformatf("vec%0d", v), vecs[v].e24, vecs[v].s24, vecs[v].e18, vecs[v].s18);
    end

    // Backpressure: result held stable, start in HOLD ignored.
    pq = '{16'sd3, 16'sd4};
    res_ready = 1'b0;
    feed("bp", 0);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_hold%0d", c), {res_valid_a, prod_ready_a, res_a}, {1'b1, 1'b0, 24'sd7});
      start = (c == 2);
      len = 8'd5;
      @(negedge clk);
    end
    start = 1'b0;
    finish_job("bp", 7, 0, 7, 0);
    check("bp_start_ignored", {busy_a, prod_ready_a}, 0);

    // len == 0: result one cycle after start, and no product is taken.
    @(negedge clk);
    check("len0_idle_ready", prod_ready_a, 0);
    start = 1'b1;
    len = 8'd0;
    prod_valid = 1'b1;
    prod_data = 16'sd55;
    @(negedge clk);
    start = 1'b0;
    check("len0_ready", prod_ready_a, 0);
    prod_valid = 1'b0;
    finish_job("len0", 0, 0, 0, 0);

    // Asynchronous reset mid-accumulation, then a clean one-product job.
    @(negedge clk);
    start = 1'b1;
    len = 8'd5;
    @(negedge clk);
    start = 1'b0;
    prod_valid = 1'b1;
    prod_data = 16'sd1000;
    @(negedge clk);
    prod_data = 16'sd2000;
    @(negedge clk);
    prod_data = 16'sd3000;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_outputs24", {busy_a, prod_ready_a, res_valid_a, res_sat_a, res_a}, 0);
    check("arst_outputs18", {busy_b, prod_ready_b, res_valid_b, res_sat_b, res_b}, 0);
    prod_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pq = '{-16'sd1};
    feed("post_rst", 0);
    finish_job("post_rst", -1, 0, -1, 0);

    // Randomized jobs, some biased to saturate the 18-bit instance.
    for (int j = 0; j < 20; j++) begin
      int n;
      bit big;
      bit neg;
      n = $urandom_range(1, 12);
      big = $urandom_range(0, 1);
      neg = $urandom_range(0, 1);
      pq.delete();
      for (int i = 0; i < n; i++) begin
        if (big) pq.push_back(neg ? 16'(-16256 + int'($urandom_range(0, 1500)))
                                  : 16'(16384 - int'($urandom_range(0, 1500))));
        else     pq.push_back(16'(int'($urandom_range(0, 32640)) - 16256));
      end
      model(24, ra, sa);
      model(18, rb, sb);
      feed($sformatf("rand%0d", j), 2);
      finish_job($sformatf("rand%0d", j), ra, sa, rb, sb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_checks);
    $fatal(1, "watchdog");
  end
endmodule
